// File: rtl/halfperiod_meter.sv
// Measures the half-period of an asynchronous square wave in clk_i cycles and
// reports it as a divider terminal value (half-period minus 1).
module halfperiod_meter #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         reset,
  input  logic         sig_i,
  input  logic         enable_i,
  output logic [N-1:0] maxval_o,
  output logic         valid_o,
  output logic         locked_o,
  output logic         timeout_o
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [N-1:0] CTR_MAX = '1;
  localparam logic [N-1:0] CTR_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state, w_stateNext;
  logic         r_sync1, r_sync2, r_hist;
  logic         w_edge;
  logic [N-1:0] r_ctr, w_ctrNext;
  logic [N-1:0] r_maxval, w_maxvalNext;
  logic         r_valid, w_validNext;
  logic         r_locked, w_lockedNext;
  logic         r_timeout, w_timeoutNext;
  logic         r_haveMeas, w_haveMeasNext;

  // The synchronizer ignores enable_i so re-enabling never sees a stale edge.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= sig_i;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 ^ r_hist;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ctr      <= '0;
      r_maxval   <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
      r_haveMeas <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_ctr      <= w_ctrNext;
      r_maxval   <= w_maxvalNext;
      r_valid    <= w_validNext;
      r_locked   <= w_lockedNext;
      r_timeout  <= w_timeoutNext;
      r_haveMeas <= w_haveMeasNext;
    end
  end

  // An edge coinciding with a full counter is still a valid measurement.
  always_comb begin
    w_stateNext    = r_state;
    w_ctrNext      = r_ctr;
    w_maxvalNext   = r_maxval;
    w_validNext    = 1'b0;
    w_lockedNext   = r_locked;
    w_timeoutNext  = r_timeout;
    w_haveMeasNext = r_haveMeas;

    if (!enable_i) begin
      w_stateNext    = IDLE;
      w_ctrNext      = '0;
      w_lockedNext   = 1'b0;
      w_haveMeasNext = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_ctrNext = '0;
          if (w_edge) w_stateNext = MEASURE;
        end
        MEASURE: begin
          if (w_edge) begin
            w_maxvalNext   = r_ctr;
            w_validNext    = 1'b1;
            w_lockedNext   = (r_ctr == r_maxval) && r_haveMeas;
            w_haveMeasNext = 1'b1;
            w_timeoutNext  = 1'b0;
            w_ctrNext      = '0;
          end else if (r_ctr == CTR_MAX) begin
            w_stateNext    = IDLE;
            w_ctrNext      = '0;
            w_timeoutNext  = 1'b1;
            w_lockedNext   = 1'b0;
            w_haveMeasNext = 1'b0;
          end else begin
            w_ctrNext = r_ctr + CTR_ONE;
          end
        end
      endcase
    end
  end

  assign maxval_o  = r_maxval;
  assign valid_o   = r_valid;
  assign locked_o  = r_locked;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_halfperiod_meter.sv
// Scoreboard bench for halfperiod_meter: each sig_i toggle queues the expected
// measurement; a monitor pops and compares whenever valid_o is seen.
module tb_halfperiod_meter;

  localparam int N = 8;

  logic         clk_i = 1'b0;
  logic         reset;
  logic         sig_i;
  logic         enable_i;
  logic [N-1:0] maxval_o;
  logic         valid_o;
  logic         locked_o;
  logic         timeout_o;

  typedef struct {
    logic [N-1:0] maxval;
    logic         locked;
    logic         timeout;
  } exp_t;

  exp_t expQ[$];
  exp_t got;
  int   nVectors     = 0;
  int   nMiscompares = 0;

  always #5 clk_i = ~clk_i;

  halfperiod_meter #(.N(N)) dut (
    .clk_i    (clk_i),
    .reset    (reset),
    .sig_i    (sig_i),
    .enable_i (enable_i),
    .maxval_o (maxval_o),
    .valid_o  (valid_o),
    .locked_o (locked_o),
    .timeout_o(timeout_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Toggle sig_i (called on a negedge); if this edge should yield a
  // measurement, queue it, then let waitCycles clocks pass.
  task automatic applyStimulus(input int waitCycles, input bit expValid,
                               input logic [N-1:0] expMax, input bit expLock);
    exp_t e;
    sig_i = ~sig_i;
    if (expValid) begin
      e.maxval  = expMax;
      e.locked  = expLock;
      e.timeout = 1'b0;
      expQ.push_back(e);
    end
    repeat (waitCycles) @(negedge clk_i);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedValid", valid_o, 1'b0);
        end else begin
          got = expQ.pop_front();
          checkOutput("maxval", maxval_o, got.maxval);
          checkOutput("locked", locked_o, got.locked);
          checkOutput("timeoutAtValid", timeout_o, got.timeout);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    enable_i = 1'b1;
    sig_i    = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("resetMaxval", maxval_o, 0);
    checkOutput("resetValid", valid_o, 0);
    checkOutput("resetLocked", locked_o, 0);
    checkOutput("resetTimeout", timeout_o, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_i);

    // Period 4, then switch to 11 while locked.
    applyStimulus(4, 0, 8'd0, 0);
    applyStimulus(4, 1, 8'd3, 0);
    applyStimulus(4, 1, 8'd3, 1);
    applyStimulus(11, 1, 8'd3, 1);
    applyStimulus(11, 1, 8'd10, 0);
    applyStimulus(11, 1, 8'd10, 1);

    // Hold sig_i: timeout lands 259 negedges after the last toggle.
    repeat (247) @(negedge clk_i);
    checkOutput("preTimeout", timeout_o, 0);
    checkOutput("preTimeoutLocked", locked_o, 1);
    @(negedge clk_i);
    checkOutput("timeoutSet", timeout_o, 1);
    checkOutput("timeoutLocked", locked_o, 0);
    checkOutput("timeoutMaxvalHeld", maxval_o, 8'd10);

    applyStimulus(4, 0, 8'd0, 0);
    checkOutput("timeoutSticky", timeout_o, 1);
    applyStimulus(4, 1, 8'd3, 0);
    checkOutput("timeoutCleared", timeout_o, 0);
    applyStimulus(4, 1, 8'd3, 1);

    // Toggle every 256: full-scale measurements, no timeout.
    applyStimulus(256, 1, 8'd3, 1);
    applyStimulus(256, 1, 8'd255, 0);
    applyStimulus(256, 1, 8'd255, 1);
    checkOutput("noTimeoutAt256", timeout_o, 0);

    // Toggle every 257: each interval times out, no measurements.
    applyStimulus(257, 1, 8'd255, 1);
    applyStimulus(257, 0, 8'd0, 0);
    checkOutput("timeoutAt257", timeout_o, 1);
    applyStimulus(257, 0, 8'd0, 0);
    checkOutput("timeoutAt257Again", timeout_o, 1);
    checkOutput("lockedAt257", locked_o, 0);

    // Relock at 4, then drop enable_i for one cycle.
    applyStimulus(4, 0, 8'd0, 0);
    applyStimulus(4, 1, 8'd3, 0);
    applyStimulus(4, 1, 8'd3, 1);
    applyStimulus(4, 1, 8'd3, 1);
    enable_i = 1'b0;
    @(negedge clk_i);
    checkOutput("disableLocked", locked_o, 0);
    checkOutput("disableMaxvalHeld", maxval_o, 8'd3);
    checkOutput("disableTimeoutHeld", timeout_o, 0);
    enable_i = 1'b1;
    repeat (3) @(negedge clk_i);
    applyStimulus(4, 0, 8'd0, 0);
    applyStimulus(4, 1, 8'd3, 0);
    applyStimulus(4, 1, 8'd3, 1);

    // Reset mid-count with sig_i high.
    reset = 1'b1;
    sig_i = 1'b1;
    @(negedge clk_i);
    checkOutput("midResetMaxval", maxval_o, 0);
    checkOutput("midResetValid", valid_o, 0);
    checkOutput("midResetLocked", locked_o, 0);
    checkOutput("midResetTimeout", timeout_o, 0);
    @(negedge clk_i);
    reset = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("postResetValid", valid_o, 0);
    repeat (300) @(negedge clk_i);
    checkOutput("resetRefTimeout", timeout_o, 1);
    checkOutput("resetRefMaxval", maxval_o, 0);
    applyStimulus(4, 0, 8'd0, 0);
    applyStimulus(4, 1, 8'd3, 0);
    applyStimulus(4, 1, 8'd3, 1);

    repeat (6) @(negedge clk_i);
    checkOutput("pendingExpectations", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/halfperiod_meter.md
HALFPERIOD_METER -- requirements
Module: halfperiod_meter

Interface
REQ-001 SHALL have parameter: N, 8, width of counter and measured value.
REQ-002 SHALL have port: clk_i  input  1  system clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset; clock clk_i.
REQ-004 SHALL have port: sig_i  input  1  square wave to measure; asynchronous to clk_i.
REQ-005 SHALL have port: enable_i  input  1  measurement enable.
REQ-006 SHALL have port: maxval_o  output  N  last measured half-period minus 1, in clk_i cycles (divider terminal value that reproduces sig_i).
REQ-007 SHALL have port: valid_o  output  1  one-cycle pulse when maxval_o updates.
REQ-008 SHALL have port: locked_o  output  1  high while two consecutive measurements are equal.
REQ-009 SHALL have port: timeout_o  output  1  sticky; no sig_i edge within 2^N cycles.

Function
REQ-010 SHALL pass sig_i through a 2-flop synchronizer (s1, s2) plus a history flop s3; edge = s2 XOR s3; both rising and falling edges count.
REQ-011 SHALL keep the synchronizer and history flops running regardless of enable_i.
REQ-012 SHALL implement FSM states IDLE (no reference edge yet) and MEASURE (counting since last edge).
REQ-013 SHALL keep an N-bit counter ctr: cleared on any edge cycle, incremented by 1 on every other MEASURE cycle, held at 0 in IDLE.
REQ-014 IDLE, edge, enable_i=1 -> MEASURE, ctr<=0; no valid_o (first edge has no reference).
REQ-015 MEASURE, edge -> maxval_o<=ctr, valid_o<=1 next cycle, ctr<=0, stay MEASURE.
REQ-016 Half-period H cycles between edges SHALL give maxval_o = H-1; minimum H=1 gives maxval_o=0.
REQ-017 On the REQ-015 update, locked_o <= (ctr == maxval_o) AND have_meas; have_meas set by every valid update.
REQ-018 On the REQ-015 update, timeout_o SHALL clear to 0.
REQ-019 MEASURE, no edge, ctr == 2^N-1 -> IDLE, ctr<=0, timeout_o<=1, locked_o<=0, have_meas<=0; maxval_o holds.
REQ-020 Simultaneous edge and ctr == 2^N-1 SHALL follow REQ-015 (valid, maxval_o=2^N-1); no timeout.
REQ-021 enable_i=0 SHALL force IDLE, ctr=0, valid_o=0, locked_o=0, have_meas=0; maxval_o and timeout_o hold.
REQ-022 After re-enable, two edges SHALL be required before the next valid_o and three before locked_o.
REQ-023 Latency: sig_i change to edge detection = 2-3 clk_i cycles (synchronizer); edge-detect cycle to valid_o/maxval_o = 1 cycle. Latency is constant, so the measured interval is unaffected.
REQ-024 valid_o SHALL never be high for two consecutive cycles unless consecutive edges are one cycle apart (maxval_o=0).

Reset
REQ-025 reset SHALL set state=IDLE, ctr=0, s1=s2=s3=0, maxval_o=0, valid_o=0, locked_o=0, timeout_o=0, have_meas=0.
REQ-026 reset mid-measurement SHALL discard the partial count; no valid_o during or on the first cycle after reset.
REQ-027 sig_i=1 at reset release SHALL produce one edge, which counts only as the IDLE reference edge.

Verification
REQ-028 N=8, sig_i toggling every 4 cycles (synchronous) -> first valid_o after the 2nd edge with maxval_o=3, locked_o=0; 2nd valid_o has maxval_o=3, locked_o=1; timeout_o=0 throughout.
REQ-029 Locked at 3, then period switched to toggle every 11 cycles -> first new valid_o: maxval_o=10, locked_o=0; next: maxval_o=10, locked_o=1.
REQ-030 Locked, then sig_i held constant -> timeout_o=1, locked_o=0 exactly 257 cycles after the last edge-detect cycle; maxval_o keeps its old value; on the next two edges: one valid_o and timeout_o=0.
REQ-031 Toggle every 256 cycles -> valid_o with maxval_o=255 each edge, timeout_o never set; toggle every 257 cycles -> timeout_o set each period, valid_o never.
REQ-032 enable_i dropped for 1 cycle mid-stream (period 4) -> locked_o=0 immediately, no valid_o until the 2nd edge after re-enable, locked_o=1 at the 3rd.
REQ-033 reset pulsed mid-count with sig_i=1 -> all outputs 0 next cycle; first valid_o only after two real edges following the reset-induced reference edge.
